// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the MM:SS stopwatch core.
package stopwatch_pkg;

    // Run-control state encoding
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } sw_state_e;

    // Digit-select codes seen by the scan stage (leftmost digit first)
    typedef enum logic [1:0] {
        SSD_DIG3 = 2'b00,
        SSD_DIG2 = 2'b01,
        SSD_DIG1 = 2'b10,
        SSD_DIG0 = 2'b11
    } ssd_sel_e;

    localparam int unsigned DIG_W        = 4;
    localparam int unsigned UNITS_MAX    = 9;
    localparam int unsigned SEC_TENS_MAX = 5;
    localparam int unsigned MIN_TENS_MAX = 5;

endpackage

// File: rtl/stopwatch_bcd_digit_cnt.sv
// One BCD digit of the stopwatch carry chain; wraps MAX -> 0 and carries.
module bcd_digit_cnt
    import stopwatch_pkg::*;
#(
    parameter int unsigned MAX = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [DIG_W-1:0] val,
    output logic             carry
);

    localparam logic [DIG_W-1:0] LAST = DIG_W'(MAX);

    // Digit register: clear has priority over increment
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            val <= '0;
        end else if (inc) begin
            val <= (val == LAST) ? '0 : val + DIG_W'(1);
        end
    end

    // Carry must ripple in the same cycle as the increment
    assign carry = inc && (val == LAST);

endmodule

// File: rtl/stopwatch_ctl.sv
// MM:SS stopwatch core feeding the 4-digit seven-segment scan stage.
// Optional feature macro: LAP_HOLD_EN (adds btn_lap and a display freeze).
module stopwatch_ctl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 100_000_000,
    parameter int unsigned SCAN_BITS = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_clr,
`ifdef LAP_HOLD_EN
    input  logic             btn_lap,
`endif
    output logic [DIG_W-1:0] dig0,
    output logic [DIG_W-1:0] dig1,
    output logic [DIG_W-1:0] dig2,
    output logic [DIG_W-1:0] dig3,
    output logic [1:0]       ssd_ctl_en,
    output logic             running,
    output logic             tick
);

    localparam int unsigned   PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic                 start_q;
    logic                 clr_q;
    logic                 start_edge;
    logic                 clr_edge;
    sw_state_e            state;
    sw_state_e            state_next;
    logic [PRE_W-1:0]     presc;
    logic [PRE_W-1:0]     presc_next;
    logic                 clr_digits;
    logic [SCAN_BITS-1:0] scan_cnt;
    logic [DIG_W-1:0]     cnt0, cnt1, cnt2, cnt3;
    logic                 c0, c1, c2;
    logic                 wrap_unused;

    assign start_edge = btn_start & ~start_q;
    assign clr_edge   = btn_clr & ~clr_q;

    // Button history; reset high so a button held through reset gives no edge
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b1;
            clr_q   <= 1'b1;
        end else begin
            start_q <= btn_start;
            clr_q   <= btn_clr;
        end
    end

    // State, prescaler and registered status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            presc   <= '0;
            running <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= state_next;
            presc   <= presc_next;
            running <= (state_next == ST_RUN);
            tick    <= (state_next == ST_RUN) && (presc_next == PRE_LAST);
        end
    end

    // Run/pause/clear control and prescaler advance
    always_comb begin
        state_next = state;
        presc_next = presc;
        clr_digits = 1'b0;
        case (state)
            ST_IDLE: begin
                if (clr_edge) begin
                    clr_digits = 1'b1;
                end else if (start_edge) begin
                    state_next = ST_RUN;
                    presc_next = '0;
                end
            end
            ST_RUN: begin
                // A tick cycle always wraps; otherwise a pausing start freezes the count
                if (presc == PRE_LAST) begin
                    presc_next = '0;
                end else if (!start_edge) begin
                    presc_next = presc + PRE_W'(1);
                end
                if (start_edge) begin
                    state_next = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (clr_edge) begin
                    state_next = ST_IDLE;
                    clr_digits = 1'b1;
                end else if (start_edge) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Free-running refresh counter; top two bits select the scanned digit
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
        end else begin
            scan_cnt <= scan_cnt + SCAN_BITS'(1);
        end
    end

    assign ssd_ctl_en = scan_cnt[SCAN_BITS-1 -: 2];

    bcd_digit_cnt #(.MAX(UNITS_MAX)) u_sec_units (
        .clk(clk), .rst(rst), .inc(tick), .clr(clr_digits), .val(cnt0), .carry(c0)
    );
    bcd_digit_cnt #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk(clk), .rst(rst), .inc(c0), .clr(clr_digits), .val(cnt1), .carry(c1)
    );
    bcd_digit_cnt #(.MAX(UNITS_MAX)) u_min_units (
        .clk(clk), .rst(rst), .inc(c1), .clr(clr_digits), .val(cnt2), .carry(c2)
    );
    // 59:59 rolls over to 00:00; the final carry has no consumer
    bcd_digit_cnt #(.MAX(MIN_TENS_MAX)) u_min_tens (
        .clk(clk), .rst(rst), .inc(c2), .clr(clr_digits), .val(cnt3), .carry(wrap_unused)
    );

`ifdef LAP_HOLD_EN
    logic             lap_q;
    logic             lap_edge;
    logic             frozen;
    logic [4*DIG_W-1:0] lap_hold;

    assign lap_edge = btn_lap & ~lap_q;

    // Lap freeze: toggled by lap edges in RUN, released by clear or reset
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_q    <= 1'b1;
            frozen   <= 1'b0;
            lap_hold <= '0;
        end else begin
            lap_q <= btn_lap;
            if (clr_digits) begin
                frozen <= 1'b0;
            end else if (lap_edge && (state == ST_RUN)) begin
                frozen <= !frozen;
                if (!frozen) begin
                    lap_hold <= {cnt3, cnt2, cnt1, cnt0};
                end
            end
        end
    end

    assign dig0 = frozen ? lap_hold[DIG_W-1:0]         : cnt0;
    assign dig1 = frozen ? lap_hold[2*DIG_W-1:DIG_W]   : cnt1;
    assign dig2 = frozen ? lap_hold[3*DIG_W-1:2*DIG_W] : cnt2;
    assign dig3 = frozen ? lap_hold[4*DIG_W-1:3*DIG_W] : cnt3;
`else
    assign dig0 = cnt0;
    assign dig1 = cnt1;
    assign dig2 = cnt2;
    assign dig3 = cnt3;
`endif

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Scoreboard bench for stopwatch_ctl (TICK_DIV=4, SCAN_BITS=4); honours LAP_HOLD_EN.
module tb_stopwatch_ctl;

    localparam int unsigned TDIV = 4;
    localparam logic [2:0] M_RUN = 3'b001;
    localparam logic [2:0] M_TCK = 3'b010;
    localparam logic [2:0] M_SSD = 3'b100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_start = 1'b0;
    logic       btn_clr = 1'b0;
`ifdef LAP_HOLD_EN
    logic       btn_lap = 1'b0;
`endif
    logic [3:0] dig0, dig1, dig2, dig3;
    logic [1:0] ssd_ctl_en;
    logic       running;
    logic       tick;

    always #5 clk = ~clk;

    stopwatch_ctl #(.TICK_DIV(TDIV), .SCAN_BITS(4)) dut (
        .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clr(btn_clr),
`ifdef LAP_HOLD_EN
        .btn_lap(btn_lap),
`endif
        .dig0(dig0), .dig1(dig1), .dig2(dig2), .dig3(dig3),
        .ssd_ctl_en(ssd_ctl_en), .running(running), .tick(tick)
    );

    typedef struct {
        string      name;
        logic [15:0] dig;
        logic       run;
        logic       tck;
        logic [1:0] ssd;
        logic [2:0] mask;
    } samp_t;

    samp_t       samp_q[$];
    logic [15:0] tick_q[$];
    int          checks = 0;
    int          errors = 0;
    int          tick_seen = 0;
    bit          pend = 1'b0;
    bit          tick_chk_en = 1'b1;
    samp_t       s_m;
    logic [15:0] e_m;
    bit          bad;

    wire [15:0] disp = {dig3, dig2, dig1, dig0};

    // Expected display after s seconds of counting
    function automatic logic [15:0] to_bcd(input int s);
        int m, c;
        c = s % 3600;
        m = c / 60;
        c = c % 60;
        return {4'(m / 10), 4'(m % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    task automatic expect_now(input string name, input logic [15:0] dig, input logic [2:0] mask,
                              input logic run, input logic tck, input logic [1:0] ssd);
        samp_t s;
        s.name = name; s.dig = dig; s.mask = mask; s.run = run; s.tck = tck; s.ssd = ssd;
        samp_q.push_back(s);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_start();
        btn_start = 1'b1;
        cyc(1);
        btn_start = 1'b0;
    endtask

    task automatic wait_ticks(input int n);
        int budget;
        budget = (n - tick_seen) * TDIV + 8;
        while (tick_seen < n && budget > 0) begin
            cyc(1);
            budget--;
        end
        if (tick_seen < n) begin
            checks++;
            errors++;
            $display("FAIL wait_ticks: saw %0d ticks, required %0d", tick_seen, n);
        end
    endtask

    // Monitor: pops tick expectations after each tick and sample expectations each cycle
    always @(negedge clk) begin
        if (pend) begin
            pend = 1'b0;
            if (tick_chk_en) begin
                checks++;
                if (tick_q.size() == 0) begin
                    errors++;
                    $display("FAIL tick_unexpected: dig=%h after tick %0d, none required", disp, tick_seen);
                end else begin
                    e_m = tick_q.pop_front();
                    if (disp !== e_m) begin
                        errors++;
                        $display("FAIL tick_count: after tick %0d dig=%h, required %h", tick_seen, disp, e_m);
                    end
                end
            end
        end
        if (!rst && tick === 1'b1) begin
            tick_seen++;
            pend = 1'b1;
            checks++;
            if (running !== 1'b1) begin
                errors++;
                $display("FAIL tick_outside_run: running=%b, required 1", running);
            end
        end
        while (samp_q.size() > 0) begin
            s_m = samp_q.pop_front();
            checks++;
            bad = (disp !== s_m.dig)
                || (s_m.mask[0] && running !== s_m.run)
                || (s_m.mask[1] && tick !== s_m.tck)
                || (s_m.mask[2] && ssd_ctl_en !== s_m.ssd);
            if (bad) begin
                errors++;
                $display("FAIL %s: dig=%h run=%b tick=%b ssd=%b, required dig=%h run=%b tick=%b ssd=%b (mask %b)",
                         s_m.name, disp, running, tick, ssd_ctl_en,
                         s_m.dig, s_m.run, s_m.tck, s_m.ssd, s_m.mask);
            end
        end
    end

    initial begin
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;

        // Idle after reset: zero display, refresh select steps every 4 cycles
        for (int i = 0; i < 64; i++) begin
            expect_now("idle_scan", 16'h0000, M_RUN | M_TCK | M_SSD, 1'b0, 1'b0, 2'((i / 4) % 4));
            cyc(1);
        end

        // Count from zero through 59:59 and the rollover
        for (int k = 1; k <= 3600; k++) tick_q.push_back(to_bcd(k));
        press_start();
        expect_now("start_entry", 16'h0000, M_RUN | M_TCK, 1'b1, 1'b0, 2'b00);
        cyc(2);
        expect_now("pre_first_tick", 16'h0000, M_TCK, 1'b0, 1'b0, 2'b00);
        cyc(1);
        expect_now("first_tick", 16'h0000, M_RUN | M_TCK, 1'b1, 1'b1, 2'b00);
        cyc(37);
        expect_now("run_00_10", 16'h0010, M_RUN, 1'b1, 1'b0, 2'b00);
        wait_ticks(599);
        expect_now("run_09_59", 16'h0959, M_RUN, 1'b1, 1'b0, 2'b00);
        wait_ticks(600);
        expect_now("run_10_00", 16'h1000, M_RUN, 1'b1, 1'b0, 2'b00);
        wait_ticks(3599);
        expect_now("run_59_59", 16'h5959, M_RUN, 1'b1, 1'b0, 2'b00);
        wait_ticks(3600);
        expect_now("wrap_00_00", 16'h0000, M_RUN, 1'b1, 1'b0, 2'b00);

        // Pause with prescaler at 2, hold, then resume from the held prescaler
        cyc(2);
        press_start();
        expect_now("pause_p2", 16'h0000, M_RUN | M_TCK, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            expect_now("pause_hold", 16'h0000, M_RUN | M_TCK, 1'b0, 1'b0, 2'b00);
        end
        tick_q.push_back(to_bcd(1));
        press_start();
        expect_now("resume", 16'h0000, M_RUN | M_TCK, 1'b1, 1'b0, 2'b00);
        cyc(1);
        expect_now("resume_tick", 16'h0000, M_RUN | M_TCK, 1'b1, 1'b1, 2'b00);
        cyc(1);
        expect_now("after_resume", 16'h0001, M_RUN | M_TCK, 1'b1, 1'b0, 2'b00);
        press_start();
        expect_now("pause_again", 16'h0001, M_RUN, 1'b0, 1'b0, 2'b00);

        // Simultaneous clear and start while paused: clear wins
        btn_clr = 1'b1;
        btn_start = 1'b1;
        cyc(1);
        btn_clr = 1'b0;
        btn_start = 1'b0;
        expect_now("clr_start_idle", 16'h0000, M_RUN | M_TCK, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 6; i++) begin
            cyc(1);
            expect_now("idle_stays", 16'h0000, M_RUN | M_TCK, 1'b0, 1'b0, 2'b00);
        end

        // Clear while running is ignored
        tick_q.push_back(to_bcd(1));
        press_start();
        btn_clr = 1'b1;
        cyc(1);
        btn_clr = 1'b0;
        expect_now("clr_in_run", 16'h0000, M_RUN, 1'b1, 1'b0, 2'b00);
        wait_ticks(tick_seen + 1);
        expect_now("clr_ignored", 16'h0001, M_RUN, 1'b1, 1'b0, 2'b00);
        press_start();
        expect_now("pause_before_rst", 16'h0001, M_RUN, 1'b0, 1'b0, 2'b00);

        // Reset with start held: state returns to idle and the held button gives no edge
        btn_start = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        expect_now("reset_state", 16'h0000, M_RUN | M_TCK | M_SSD, 1'b0, 1'b0, 2'b00);
        for (int i = 0; i < 10; i++) begin
            cyc(1);
            expect_now("start_held", 16'h0000, M_RUN | M_TCK, 1'b0, 1'b0, 2'b00);
        end
        btn_start = 1'b0;
        cyc(2);
        expect_now("held_release", 16'h0000, M_RUN, 1'b0, 1'b0, 2'b00);

`ifdef LAP_HOLD_EN
        // Lap freeze at 00:03, internal count continues, release shows 00:08
        tick_chk_en = 1'b0;
        press_start();
        wait_ticks(tick_seen + 3);
        expect_now("lap_pre", 16'h0003, M_RUN, 1'b1, 1'b0, 2'b00);
        btn_lap = 1'b1;
        cyc(1);
        btn_lap = 1'b0;
        expect_now("lap_frozen_now", 16'h0003, M_RUN, 1'b1, 1'b0, 2'b00);
        wait_ticks(tick_seen + 5);
        expect_now("lap_frozen", 16'h0003, M_RUN, 1'b1, 1'b0, 2'b00);
        btn_lap = 1'b1;
        cyc(1);
        btn_lap = 1'b0;
        expect_now("lap_release", 16'h0008, M_RUN, 1'b1, 1'b0, 2'b00);
        press_start();
        btn_clr = 1'b1;
        cyc(1);
        btn_clr = 1'b0;
        expect_now("lap_clr", 16'h0000, M_RUN, 1'b0, 1'b0, 2'b00);
`endif

        cyc(2);
        checks++;
        if (tick_q.size() != 0) begin
            errors++;
            $display("FAIL tick_queue_drained: %0d ticks outstanding, required 0", tick_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
